// File: rtl/gray_ptr_counter_pkg.sv
// rtl/gray_ptr_counter_pkg.sv - Gray codec helpers shared by the pointer counter, its consumers and benches
package gray_ptr_counter_pkg;

    localparam int MAX_WIDTH = 32;

    typedef logic [MAX_WIDTH-1:0] word_t;

    // Callers zero-extend narrower values; the upper zeros do not disturb the low bits.
    function automatic word_t bin2gray(input word_t x);
        return x ^ (x >> 1);
    endfunction

    function automatic word_t gray2bin(input word_t g);
        word_t b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_ptr_counter_bin2gray_comb.sv
// rtl/gray_ptr_counter_bin2gray_comb.sv - combinational binary-to-Gray encoder
module bin2gray_comb
    import gray_ptr_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    word_t gray_wide;

    assign gray_wide = bin2gray(word_t'(bin_i));
    assign gray_o    = gray_wide[WIDTH-1:0];

endmodule

// File: rtl/gray_ptr_counter.sv
// rtl/gray_ptr_counter.sv - registered up/down binary counter with flopped Gray output and wrap pulse
module gray_ptr_counter
    import gray_ptr_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_val;
        end else if (en) begin
            if (up) begin
                bin_d  = bin_q + ONE;
                wrap_d = &bin_q;
            end else begin
                bin_d  = bin_q - ONE;
                wrap_d = ~|bin_q;
            end
        end
    end

    // Gray is encoded from the next binary value so the output bus comes straight off flops.
    bin2gray_comb #(.WIDTH(WIDTH)) u_enc (
        .bin_i (bin_d),
        .gray_o(gray_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_gray_ptr_counter.sv
// tb/tb_gray_ptr_counter.sv - randomized and directed bench for gray_ptr_counter against a modular-arithmetic model
module tb_gray_ptr_counter;
    import gray_ptr_counter_pkg::*;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;

    int n_checks = 0;
    int n_fail   = 0;

    int m_bin  = 0;
    int m_wrap = 0;

    int sweep_gray [16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

    gray_ptr_counter #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .up      (up),
        .load    (load),
        .load_val(load_val),
        .bin     (bin),
        .gray    (gray),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic l, input logic [W-1:0] lv,
                        input logic e, input logic u);
        logic [W-1:0] prev_gray;
        logic         en_only;
        word_t        decoded;
        prev_gray = gray;
        en_only   = !r && !l && e;
        rst = r; load = l; load_val = lv; en = e; up = u;
        @(posedge clk);
        #1;
        if (r) begin
            m_bin = 0; m_wrap = 0;
        end else if (l) begin
            m_bin = int'(lv); m_wrap = 0;
        end else if (e && u) begin
            m_wrap = (m_bin == MOD - 1) ? 1 : 0;
            m_bin  = (m_bin + 1) % MOD;
        end else if (e) begin
            m_wrap = (m_bin == 0) ? 1 : 0;
            m_bin  = (m_bin + MOD - 1) % MOD;
        end else begin
            m_wrap = 0;
        end
        check_eq("bin", 32'(bin), 32'(m_bin));
        check_eq("gray", 32'(gray), 32'(m_bin ^ (m_bin / 2)));
        check_eq("wrap", 32'(wrap), 32'(m_wrap));
        decoded = gray2bin(word_t'(gray));
        check_eq("gray2bin", decoded, 32'(m_bin));
        if (en_only) check_eq("one_bit_step", 32'($countones(gray ^ prev_gray)), 32'd1);
    endtask

    initial begin
        // Reset dominates a simultaneous load and enable.
        step(1, 1, 4'b1010, 1, 1);
        step(1, 1, 4'b1010, 1, 1);
        check_eq("reset_bin", 32'(bin), 32'd0);

        // Full upward sweep through the wrap.
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 4'd0, 1, 1);
            check_eq("sweep_gray", 32'(gray), 32'(sweep_gray[i]));
            check_eq("sweep_wrap", 32'(wrap), (i == 15) ? 32'd1 : 32'd0);
        end

        // Downward wrap out of reset.
        step(1, 0, 4'd0, 0, 0);
        step(0, 0, 4'd0, 1, 0);
        check_eq("down_wrap_gray", 32'(gray), 32'b1000);
        check_eq("down_wrap_pulse", 32'(wrap), 32'd1);
        step(0, 0, 4'd0, 1, 0);
        check_eq("down_next_gray", 32'(gray), 32'b1001);

        // Load beats enable.
        step(1, 0, 4'd0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 4'd0, 1, 1);
        step(0, 1, 4'b1010, 1, 1);
        check_eq("load_gray", 32'(gray), 32'b1111);
        step(0, 0, 4'd0, 1, 1);
        check_eq("load_then_up_gray", 32'(gray), 32'b1110);

        // Hold, then reverse direction every cycle.
        step(0, 1, 4'b0101, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 4'd0, 0, 1);
        check_eq("hold_gray", 32'(gray), 32'b0111);
        for (int i = 0; i < 6; i++) step(0, 0, 4'd0, 1, (i % 2) == 0);

        // Reset in the middle of counting.
        step(0, 1, 4'b1101, 0, 0);
        step(0, 0, 4'd0, 1, 1);
        step(1, 0, 4'd0, 1, 1);
        check_eq("midreset_bin", 32'(bin), 32'd0);
        step(0, 0, 4'd0, 1, 1);
        check_eq("resume_bin", 32'(bin), 32'd1);

        // Random mix weighted toward counting.
        for (int i = 0; i < 600; i++) begin
            logic r, l, e, u;
            logic [W-1:0] lv;
            r  = ($urandom_range(0, 49) == 0);
            l  = ($urandom_range(0, 14) == 0);
            e  = ($urandom_range(0, 4) != 0);
            u  = ($urandom_range(0, 2) != 0);
            lv = W'($urandom);
            step(r, l, lv, e, u);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
